// File: rtl/clk_rate_sequencer.sv
// Bit/frame clock generator for the converter serial ports. A new divide ratio is handed over
// only at a frame boundary, after a silent gap, so bck/lrck never show a runt or glitch.
module clk_rate_sequencer #(
  parameter int B             = 16,
  parameter int DEFAULT_RATIO = 4,
  parameter int LR_DIV        = 64,
  parameter int GAP           = 8
) (
  input  logic         clkin,
  input  logic         reset,
  input  logic [B-1:0] cfg_ratio,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         bck,
  output logic         lrck,
  output logic         frame_start,
  output logic         running
);

  localparam int BW = $clog2(LR_DIV);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  localparam logic [B-1:0]  ONE      = B'(1);
  localparam logic [B-1:0]  TWO      = B'(2);
  localparam logic [B-1:0]  RST_RAT  = B'(DEFAULT_RATIO);
  localparam logic [BW-1:0] BIT_LAST = BW'(LR_DIV - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(LR_DIV / 2);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  logic [1:0]    state;
  logic [B-1:0]  ratio;
  logic [B-1:0]  pend;
  logic [B-1:0]  cnt;
  logic [BW-1:0] bitcnt;
  logic [GW-1:0] gapcnt;
  logic          accept;
  logic          cnt_wrap;
  logic          frame_end;

  assign cfg_ready = (state == S_RUN) && !reset;
  assign accept    = cfg_valid && cfg_ready;
  assign cnt_wrap  = (cnt == ratio - ONE);
  assign frame_end = cnt_wrap && (bitcnt == BIT_LAST);

  // Outputs are registered from the counter values seen before this edge's update.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= S_RUN;
      ratio       <= RST_RAT;
      pend        <= '0;
      cnt         <= '0;
      bitcnt      <= '0;
      gapcnt      <= '0;
      bck         <= 1'b0;
      lrck        <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= accept && (cfg_ratio < TWO);
      case (state)
        S_RUN, S_DRAIN: begin
          bck         <= (cnt < (ratio >> 1));
          lrck        <= (bitcnt >= BIT_HALF);
          frame_start <= (cnt == '0) && (bitcnt == '0);
          running     <= 1'b1;
          cnt         <= cnt_wrap ? '0 : cnt + ONE;
          if (cnt_wrap)
            bitcnt <= (bitcnt == BIT_LAST) ? '0 : bitcnt + BIT_ONE;
          // A request landing on the last frame cycle still drains one whole frame.
          if (state == S_RUN && accept && cfg_ratio >= TWO) begin
            pend  <= cfg_ratio;
            state <= S_DRAIN;
          end
          if (state == S_DRAIN && frame_end) begin
            state  <= S_GAP;
            gapcnt <= '0;
          end
        end
        S_GAP: begin
          bck         <= 1'b0;
          lrck        <= 1'b0;
          frame_start <= 1'b0;
          running     <= 1'b0;
          if (gapcnt == GAP_LAST)
            state <= S_LOAD;
          else
            gapcnt <= gapcnt + GAP_ONE;
        end
        default: begin
          bck         <= 1'b0;
          lrck        <= 1'b0;
          frame_start <= 1'b0;
          running     <= 1'b0;
          ratio       <= pend;
          cnt         <= '0;
          bitcnt      <= '0;
          state       <= S_RUN;
        end
      endcase
    end
  end

endmodule
